// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter_ctrl sequencer: state encoding and default widths.
package counter_ctrl_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int PRE_W_DEF = 4;

  localparam logic [1:0] ST_IDLE_ENC  = 2'b00;
  localparam logic [1:0] ST_RUN_ENC   = 2'b01;
  localparam logic [1:0] ST_PAUSE_ENC = 2'b10;
  localparam logic [1:0] ST_DONE_ENC  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_RUN   = ST_RUN_ENC,
    ST_PAUSE = ST_PAUSE_ENC,
    ST_DONE  = ST_DONE_ENC
  } state_e;

endpackage

// File: rtl/cnt_prescaler.sv
// Step divider: counts enabled cycles and flags a step when the count reaches limit.
module cnt_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] limit,
  output logic             step
);

  logic [PRE_W-1:0] cnt_q;

  assign step = en && (cnt_q == limit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= step ? '0 : cnt_q + PRE_W'(1);
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Start/hold/abort sequencer for a prescaled up counter with terminal-count wrap and one-shot done.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int PRE_W = PRE_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  input  logic             abort,
  input  logic             periodic,
  input  logic [WIDTH-1:0] term,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             wrap,
  output logic             done,
  output logic [1:0]       state
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] term_q;
  logic [PRE_W-1:0] pre_q;
  logic             per_q;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             cfg_ld;
  logic             pre_en;
  logic             pre_clr;
  logic             step;

  // Prescaler only advances in an uninterrupted RUN cycle; abort and hold both suppress the step.
  assign pre_en  = (state_q == ST_RUN) && !abort && !hold;
  assign pre_clr = ((state_q == ST_IDLE) && start) || ((state_q != ST_IDLE) && abort);

  cnt_prescaler #(
    .PRE_W (PRE_W)
  ) u_pre (
    .clk   (clk),
    .rst   (rst),
    .en    (pre_en),
    .clr   (pre_clr),
    .limit (pre_q),
    .step  (step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      term_q  <= '0;
      pre_q   <= '0;
      per_q   <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      if (cfg_ld) begin
        term_q <= term;
        pre_q  <= prescale;
        per_q  <= periodic;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    cfg_ld  = 1'b0;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_ld  = 1'b1;
          count_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          count_d = '0;
          state_d = ST_IDLE;
        end else if (hold) begin
          state_d = ST_PAUSE;
        end else if (step) begin
          if (count_q == term_q) begin
            wrap_d = 1'b1;
            if (per_q) begin
              count_d = '0;
            end else begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end
      ST_PAUSE: begin
        if (abort) begin
          count_d = '0;
          state_d = ST_IDLE;
        end else if (!hold) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (abort) begin
          count_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign count = count_q;
  assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign wrap  = wrap_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: directed stimulus queues expected outputs, a monitor checks them.
module tb_counter_ctrl;
  import counter_ctrl_pkg::*;

  localparam logic [1:0] I = 2'b00;
  localparam logic [1:0] R = 2'b01;
  localparam logic [1:0] P = 2'b10;
  localparam logic [1:0] D = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, hold = 1'b0, abort = 1'b0, periodic = 1'b0;
  logic [3:0] term = '0, prescale = '0;
  logic [3:0] count;
  logic       busy, wrap, done;
  logic [1:0] state;

  typedef struct packed {
    logic [3:0] cnt;
    logic [1:0] st;
    logic       busy;
    logic       w;
    logic       d;
  } obs_t;

  obs_t  q[$];
  string nq[$];
  int    total = 0;
  int    bad = 0;

  counter_ctrl #(.WIDTH(4), .PRE_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .hold     (hold),
    .abort    (abort),
    .periodic (periodic),
    .term     (term),
    .prescale (prescale),
    .count    (count),
    .busy     (busy),
    .wrap     (wrap),
    .done     (done),
    .state    (state)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(logic [3:0] c, logic [1:0] s, logic w, logic d);
    obs_t o;
    o.cnt  = c;
    o.st   = s;
    o.busy = (s == R) || (s == P);
    o.w    = w;
    o.d    = d;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.cnt  = count;
    o.st   = state;
    o.busy = busy;
    o.w    = wrap;
    o.d    = done;
    return o;
  endfunction

  task automatic cmp(string nm, obs_t got, obs_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got cnt=%0d st=%0d busy=%0b wrap=%0b done=%0b, want cnt=%0d st=%0d busy=%0b wrap=%0b done=%0b",
               nm, got.cnt, got.st, got.busy, got.w, got.d, exp.cnt, exp.st, exp.busy, exp.w, exp.d);
    end
  endtask

  // Drive inputs for one cycle and queue the outputs expected after the next rising edge.
  task automatic cyc(string nm, logic s, logic h, logic a,
                     logic [3:0] c, logic [1:0] st, logic w, logic d);
    @(negedge clk);
    start = s;
    hold  = h;
    abort = a;
    q.push_back(mk(c, st, w, d));
    nq.push_back(nm);
    @(posedge clk);
  endtask

  // Start a sequence, then scramble the config inputs to prove they were latched.
  task automatic arm(string nm, logic per, logic [3:0] t, logic [3:0] p);
    @(negedge clk);
    periodic = per;
    term     = t;
    prescale = p;
    start    = 1'b1;
    hold     = 1'b0;
    abort    = 1'b0;
    q.push_back(mk(4'd0, R, 1'b0, 1'b0));
    nq.push_back(nm);
    @(posedge clk);
    #1;
    periodic = ~per;
    term     = ~t;
    prescale = ~p;
    start    = 1'b0;
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        cmp(nq.pop_front(), sample(), q.pop_front());
      end
    end
  end

  initial begin : stim
    logic [3:0] pc[6];
    pc[0] = 4'd0; pc[1] = 4'd1; pc[2] = 4'd1; pc[3] = 4'd2; pc[4] = 4'd2; pc[5] = 4'd0;

    #1;
    cmp("reset_t0", sample(), mk(4'd0, I, 1'b0, 1'b0));
    cyc("reset_hold0", 1'b1, 1'b0, 1'b0, 4'd0, I, 1'b0, 1'b0);
    cyc("reset_hold1", 1'b0, 1'b0, 1'b0, 4'd0, I, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // one-shot, term=3, prescale=0
    arm("os_start", 1'b0, 4'd3, 4'd0);
    cyc("os_c1", 1'b0, 1'b0, 1'b0, 4'd1, R, 1'b0, 1'b0);
    cyc("os_c2", 1'b0, 1'b0, 1'b0, 4'd2, R, 1'b0, 1'b0);
    cyc("os_c3", 1'b0, 1'b0, 1'b0, 4'd3, R, 1'b0, 1'b0);
    cyc("os_term", 1'b0, 1'b0, 1'b0, 4'd3, D, 1'b1, 1'b1);
    cyc("os_done_start_ign", 1'b1, 1'b0, 1'b0, 4'd3, I, 1'b0, 1'b0);
    cyc("os_idle_hold", 1'b0, 1'b0, 1'b0, 4'd3, I, 1'b0, 1'b0);

    // periodic, term=2, prescale=1
    arm("per_start", 1'b1, 4'd2, 4'd1);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6; i++) begin
        cyc("per_run", 1'b0, 1'b0, 1'b0, pc[i], R, (i == 5), 1'b0);
      end
    end
    cyc("per_abort", 1'b0, 1'b0, 1'b1, 4'd0, I, 1'b0, 1'b0);

    // hold for 5 cycles at count=1, one-shot term=3 prescale=1
    arm("hold_start", 1'b0, 4'd3, 4'd1);
    cyc("hold_c0", 1'b0, 1'b0, 1'b0, 4'd0, R, 1'b0, 1'b0);
    cyc("hold_c1", 1'b0, 1'b0, 1'b0, 4'd1, R, 1'b0, 1'b0);
    cyc("hold_c1b", 1'b0, 1'b0, 1'b0, 4'd1, R, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc("hold_pause", 1'b0, 1'b1, 1'b0, 4'd1, P, 1'b0, 1'b0);
    end
    cyc("hold_release", 1'b0, 1'b0, 1'b0, 4'd1, R, 1'b0, 1'b0);
    cyc("hold_c2", 1'b0, 1'b0, 1'b0, 4'd2, R, 1'b0, 1'b0);
    cyc("hold_c2b", 1'b0, 1'b0, 1'b0, 4'd2, R, 1'b0, 1'b0);
    cyc("hold_c3", 1'b0, 1'b0, 1'b0, 4'd3, R, 1'b0, 1'b0);
    cyc("hold_c3b", 1'b0, 1'b0, 1'b0, 4'd3, R, 1'b0, 1'b0);
    cyc("hold_term", 1'b0, 1'b0, 1'b0, 4'd3, D, 1'b1, 1'b1);
    cyc("hold_idle", 1'b0, 1'b0, 1'b0, 4'd3, I, 1'b0, 1'b0);

    // abort during PAUSE (abort beats hold)
    arm("abp_start", 1'b1, 4'd2, 4'd0);
    cyc("abp_c1", 1'b0, 1'b0, 1'b0, 4'd1, R, 1'b0, 1'b0);
    cyc("abp_pause", 1'b0, 1'b1, 1'b0, 4'd1, P, 1'b0, 1'b0);
    cyc("abp_abort", 1'b0, 1'b1, 1'b1, 4'd0, I, 1'b0, 1'b0);
    cyc("abp_idle", 1'b0, 1'b0, 1'b0, 4'd0, I, 1'b0, 1'b0);

    // abort coincident with terminal step
    arm("abt_start", 1'b0, 4'd1, 4'd0);
    cyc("abt_c1", 1'b0, 1'b0, 1'b0, 4'd1, R, 1'b0, 1'b0);
    cyc("abt_abort", 1'b0, 1'b0, 1'b1, 4'd0, I, 1'b0, 1'b0);
    cyc("abt_idle", 1'b0, 1'b0, 1'b0, 4'd0, I, 1'b0, 1'b0);

    // term=0, prescale=3, periodic
    arm("t0_start", 1'b1, 4'd0, 4'd3);
    for (int i = 0; i < 8; i++) begin
      cyc("t0_run", 1'b0, 1'b0, 1'b0, 4'd0, R, (i == 3) || (i == 7), 1'b0);
    end
    cyc("t0_abort", 1'b0, 1'b0, 1'b1, 4'd0, I, 1'b0, 1'b0);

    // asynchronous reset mid-run at count=2
    arm("ar_start", 1'b1, 4'd3, 4'd0);
    cyc("ar_c1", 1'b0, 1'b0, 1'b0, 4'd1, R, 1'b0, 1'b0);
    cyc("ar_c2", 1'b0, 1'b0, 1'b0, 4'd2, R, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    cmp("ar_async", sample(), mk(4'd0, I, 1'b0, 1'b0));
    q.push_back(mk(4'd0, I, 1'b0, 1'b0));
    nq.push_back("ar_held");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    arm("ar_restart", 1'b0, 4'd2, 4'd0);
    cyc("ar_r1", 1'b0, 1'b0, 1'b0, 4'd1, R, 1'b0, 1'b0);
    cyc("ar_r2", 1'b0, 1'b0, 1'b0, 4'd2, R, 1'b0, 1'b0);
    cyc("ar_rterm", 1'b0, 1'b0, 1'b0, 4'd2, D, 1'b1, 1'b1);
    cyc("ar_ridle", 1'b0, 1'b0, 1'b0, 4'd2, I, 1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
